alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
// - Issuing side of the ALU operand/result interface. Accepts ops on a valid/ready request port, drives alu_in1/alu_in2/alu_op.
// - Waits out the ALU's result and zero-flag latency, then returns result + flags on a valid/ready response port.
// - Sits between the control path and the registered N-bit ALU. Only this block drives the ALU's operand and op inputs.
// PARAMETERS
// - N          8   operand/result width; must match the attached ALU
// - CNT_W      16  width of completed-operation counter
// PORTS
// - clk        in   1      system clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - req_valid  in   1      request present
// - req_ready  out  1      block can accept a request
// - req_op     in   2      0 add, 1 sub, 2 mul, 3 reserved
// - req_a      in   N      operand A
// - req_b      in   N      operand B
// - alu_in1    out  N      to ALU in1
// - alu_in2    out  N      to ALU in2
// - alu_op     out  2      to ALU alu_op
// - alu_out    in   N      from ALU result
// - alu_z      in   N      from ALU zero flag (bit 0 significant)
// - rsp_valid  out  1      response present
// - rsp_ready  in   1      consumer takes response
// - rsp_data   out  N      result, truncated to N bits
// - rsp_zero   out  1      result equals 0
// - rsp_err    out  1      reserved op requested; no ALU cycle issued
// - ops_done   out  CNT_W  count of completed response handshakes, wraps at 2^CNT_W
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE. All outputs 0 except req_ready=1. ops_done=0.
// - FSM states: IDLE, EXEC, SETTLE, CAPTURE, RESP.
// - Timing chain: ALU registers alu_out 1 edge after operands change. It registers z from the previous alu_out, so z lags 1 more edge.
// - IDLE: req_ready=1.
//   - On req_valid && req_op!=3: register alu_in1=req_a, alu_in2=req_b, alu_op=req_op; go to EXEC.
//   - On req_valid && req_op==3: leave alu_* unchanged, load rsp_data=0, rsp_zero=0, rsp_err=1; go to RESP.
// - EXEC -> SETTLE -> CAPTURE: unconditional, one edge each. alu_* held constant throughout.
// - CAPTURE edge: rsp_data<=alu_out, rsp_zero<=alu_z[0], rsp_err<=0; go to RESP.
// - RESP: rsp_valid=1, req_ready=0. rsp_* held stable while rsp_ready=0.
//   - On rsp_ready: ops_done+1 (wraps), rsp_valid drops next cycle, go to IDLE.
// - Latency from accepting edge E0:
//   - Normal op: rsp_valid high after E3.
//   - Reserved op: rsp_valid high after E0 (next cycle).
// - Throughput: no overlap; req_ready only in IDLE. Minimum 5 cycles per normal op, 2 per reserved op.
// - alu_* retain the last issued op between requests, so the ALU output stays stable.
// - Width rules:
//   - Sub wraps modulo 2^N.
//   - Mul keeps the low N bits only.
//   - rsp_zero reflects the truncated value.
// - Reset mid-operation (any state): FSM aborts to IDLE. No stale response is ever presented after rst deasserts.
// - Inputs other than rsp_ready are ignored outside IDLE. rsp_ready is ignored outside RESP.
// STRUCTURE
// - Shared package holds:
//   - op encodings OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_RSV=2'd3
//   - FSM state encoding
//   - constant ALU_RES_LAT=1, ALU_Z_LAT=2
// - Single flat module, no sub-module. The ALU is instantiated beside it at the next level up, and in the bench.
// TESTING (bench: alu_sequencer + alu, N=8; cycle-check every response)
// - add 5+3 -> rsp_data=8, rsp_zero=0, rsp_err=0; rsp_valid exactly after 3rd edge post-accept.
// - add 1+1, then sub 7-7 -> first rsp 2/zero=0, second rsp 0/zero=1. Checks z-lag capture, no stale flag.
// - mul 20*13 -> rsp_data=4 (260 mod 256), rsp_zero=0. mul 16*16 -> rsp_data=0, rsp_zero=1.
// - op=3, a=9, b=9 -> rsp_err=1, rsp_data=0, rsp_valid 1 cycle after accept; alu_op unchanged from previous op.
// - rsp_ready low 6 cycles in RESP -> rsp_* stable, req_ready=0. Then handshake -> IDLE next cycle, ops_done+1. Preload ops_done to 16'hFFFF -> wraps to 0.
// - rst pulsed during SETTLE of sub 9-4 -> outputs zero immediately, req_ready=1 after release, no rsp_valid; next add 2+2 returns 4.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU issuing sequencer: op codes, FSM states and
// the attached ALU's pipeline latencies.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_RSV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Edges from operand change to a valid result, and to a valid zero flag.
  localparam int ALU_RES_LAT = 1;
  localparam int ALU_Z_LAT   = 2;

endpackage

// File: rtl/alu_sequencer.sv
// Issues one op at a time to a registered ALU, waits out its result and
// zero-flag latency, then presents the result on a valid/ready response port.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  output logic [N-1:0]     alu_in1,
  output logic [N-1:0]     alu_in2,
  output logic [1:0]       alu_op,
  input  logic [N-1:0]     alu_out,
  input  logic [N-1:0]     alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done
);

  state_t state, state_nxt;

  logic accept;
  logic reserved;

  assign reserved = (req_op == OP_RSV);
  assign accept   = (state == ST_IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = reserved ? ST_RESP : ST_EXEC;
      end
      ST_EXEC:    state_nxt = ST_SETTLE;
      ST_SETTLE:  state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands stay on the ALU between requests so its output never wanders;
  // the zero flag is sampled only at CAPTURE, once its extra lag has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_op   <= OP_ADD;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
      ops_done <= '0;
    end else begin
      if (accept && !reserved) begin
        alu_in1 <= req_a;
        alu_in2 <= req_b;
        alu_op  <= req_op;
      end
      if (accept && reserved) begin
        rsp_data <= '0;
        rsp_zero <= 1'b0;
        rsp_err  <= 1'b1;
      end
      if (state == ST_CAPTURE) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_z[0];
        rsp_err  <= 1'b0;
      end
      if (state == ST_RESP && rsp_ready) ops_done <= ops_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU beside it
// (result one edge after operands, zero flag one edge after result).
module tb_alu_sequencer;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [N-1:0]     req_a = '0;
  logic [N-1:0]     req_b = '0;
  logic [N-1:0]     alu_in1;
  logic [N-1:0]     alu_in2;
  logic [1:0]       alu_op;
  logic [N-1:0]     alu_out = '0;
  logic [N-1:0]     alu_z = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [N-1:0]     rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic [CNT_W-1:0] ops_done;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_ops = '0;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .ops_done  (ops_done)
  );

  // Behavioural registered ALU.
  always_ff @(posedge clk) begin
    case (alu_op)
      2'd0:    alu_out <= alu_in1 + alu_in2;
      2'd1:    alu_out <= alu_in1 - alu_in2;
      2'd2:    alu_out <= N'(alu_in1 * alu_in2);
      default: alu_out <= alu_out;
    endcase
    alu_z <= {{(N-1){1'b0}}, (alu_out == '0)};
  end

  // Issue one op, measure edges from accept to rsp_valid, check the response,
  // optionally stall rsp_ready, then complete the handshake.
  task automatic do_op(input string name, input logic [1:0] op,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input int exp_lat, input logic [N-1:0] exp_data,
                       input logic exp_zero, input logic exp_err,
                       input logic [N-1:0] exp_in1, input logic [1:0] exp_op,
                       input int stall);
    int e;
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready timeout: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    e = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid === 1'b1 || e >= 20) break;
      @(posedge clk);
      e++;
    end
    checks++;
    if (e != exp_lat || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (valid=%b) want %0d", name, e, rsp_valid, exp_lat);
    end
    checks++;
    if (rsp_data !== exp_data || rsp_zero !== exp_zero || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL %s response: got data=%0d zero=%b err=%b want data=%0d zero=%b err=%b",
               name, rsp_data, rsp_zero, rsp_err, exp_data, exp_zero, exp_err);
    end
    checks++;
    if (alu_in1 !== exp_in1 || alu_op !== exp_op || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s alu/ready: got in1=%0d op=%0d ready=%b want in1=%0d op=%0d ready=0",
               name, alu_in1, alu_op, req_ready, exp_in1, exp_op);
    end
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_op    = 2'd0;
      req_a     = 8'hAA;
      req_b     = 8'h55;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== exp_data ||
          rsp_zero !== exp_zero || rsp_err !== exp_err || alu_in1 !== exp_in1) begin
        errors++;
        $display("FAIL %s stall cycle %0d: got valid=%b ready=%b data=%0d zero=%b err=%b in1=%0d want 1/0/%0d/%b/%b/%0d",
                 name, i, rsp_valid, req_ready, rsp_data, rsp_zero, rsp_err, alu_in1,
                 exp_data, exp_zero, exp_err, exp_in1);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    exp_ops = exp_ops + 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ops_done !== exp_ops) begin
      errors++;
      $display("FAIL %s handshake: got valid=%b ready=%b ops_done=%0d want 0/1/%0d",
               name, rsp_valid, req_ready, ops_done, exp_ops);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_zero !== 1'b0 ||
        rsp_err !== 1'b0 || alu_in1 !== '0 || alu_in2 !== '0 || alu_op !== 2'd0 || ops_done !== '0) begin
      errors++;
      $display("FAIL reset state: ready=%b valid=%b data=%0d zero=%b err=%b in1=%0d in2=%0d op=%0d ops=%0d",
               req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_in1, alu_in2, alu_op, ops_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_op("add_5_3", 2'd0, 8'd5, 8'd3, 3, 8'd8, 1'b0, 1'b0, 8'd5, 2'd0, 0);
  endtask

  task automatic test_back_to_back();
    do_op("add_1_1", 2'd0, 8'd1, 8'd1, 3, 8'd2, 1'b0, 1'b0, 8'd1, 2'd0, 0);
    do_op("sub_7_7", 2'd1, 8'd7, 8'd7, 3, 8'd0, 1'b1, 1'b0, 8'd7, 2'd1, 0);
  endtask

  task automatic test_width();
    do_op("sub_3_5",   2'd1, 8'd3,  8'd5,  3, 8'd254, 1'b0, 1'b0, 8'd3,  2'd1, 0);
    do_op("mul_20_13", 2'd2, 8'd20, 8'd13, 3, 8'd4,   1'b0, 1'b0, 8'd20, 2'd2, 0);
    do_op("mul_16_16", 2'd2, 8'd16, 8'd16, 3, 8'd0,   1'b1, 1'b0, 8'd16, 2'd2, 0);
  endtask

  task automatic test_reserved();
    do_op("rsv_9_9", 2'd3, 8'd9, 8'd9, 0, 8'd0, 1'b0, 1'b1, 8'd16, 2'd2, 0);
  endtask

  task automatic test_stall();
    do_op("stall_add_100_50", 2'd0, 8'd100, 8'd50, 3, 8'd150, 1'b0, 1'b0, 8'd100, 2'd0, 6);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.ops_done = 16'hFFFF;
    #1;
    release dut.ops_done;
    exp_ops = 16'hFFFF;
    do_op("wrap_rsv", 2'd3, 8'd1, 8'd2, 0, 8'd0, 1'b0, 1'b1, 8'd100, 2'd0, 0);
  endtask

  task automatic test_reset_midop();
    bit seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = 8'd9;
    req_b     = 8'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_ops = '0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== '0 || rsp_err !== 1'b0 ||
        alu_in1 !== '0 || alu_op !== 2'd0 || ops_done !== '0) begin
      errors++;
      $display("FAIL midop reset immediate: valid=%b ready=%b data=%0d err=%b in1=%0d op=%0d ops=%0d",
               rsp_valid, req_ready, rsp_data, rsp_err, alu_in1, alu_op, ops_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop reset idle: got stale activity valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
    do_op("post_reset_add_2_2", 2'd0, 8'd2, 8'd2, 3, 8'd4, 1'b0, 1'b0, 8'd2, 2'd0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_width();
    test_reserved();
    test_stall();
    test_wrap();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
